// File: rtl/gaussian_pkg.sv
// Shared types, kernel constants and the per-lane arithmetic for the 3x3 Gaussian stencil.
package gaussian_pkg;

  localparam int unsigned PIX_PER_LINE = 64;
  localparam int unsigned LINE_W       = 512;
  localparam int unsigned GAUSS_RND    = 8;
  localparam int unsigned GAUSS_SHIFT  = 4;

  typedef logic [7:0] t_pixel;
  typedef logic [9:0] t_vsum;
  typedef t_pixel [PIX_PER_LINE-1:0] t_pix_line;
  typedef t_vsum  [PIX_PER_LINE-1:0] t_vsum_line;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} t_stencil_state;

  // Column sum top + 2*mid + bot; 10 bits holds the 1020 maximum.
  function automatic t_vsum_line vsum_line(t_pix_line top, t_pix_line mid, t_pix_line bot);
    t_vsum_line res;
    for (int p = 0; p < PIX_PER_LINE; p++) begin
      res[p] = {2'b00, top[p]} + {1'b0, mid[p], 1'b0} + {2'b00, bot[p]};
    end
    return res;
  endfunction

  // Row sum over 64 lanes with one neighbour lane borrowed from each adjacent line, then
  // rounded divide by 16. Maximum 4080 + 8 still fits 12 bits.
  function automatic t_pix_line hsum_line(t_vsum left, t_vsum_line v, t_vsum right);
    t_vsum [PIX_PER_LINE+1:0] ext;
    t_pix_line                res;
    logic [11:0]              s;
    ext = {right, v, left};
    for (int p = 0; p < PIX_PER_LINE; p++) begin
      s = 12'(ext[p]) + {1'b0, ext[p+1], 1'b0} + 12'(ext[p+2]) + 12'(GAUSS_RND);
      res[p] = t_pixel'(s >> GAUSS_SHIFT);
    end
    return res;
  endfunction

endpackage

// File: rtl/gaussian_line_buffer.sv
// Line RAM with registered read; a read and write to the same address return the old data.
module gaussian_line_buffer #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 512
) (
  input  logic                     clk_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(Depth)-1:0] rd_addr_i,
  output logic [Width-1:0]         rd_data_o,
  input  logic                     wr_en_i,
  input  logic [$clog2(Depth)-1:0] wr_addr_i,
  input  logic [Width-1:0]         wr_data_i
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gaussian_stencil.sv
// Streaming 3x3 Gaussian filter over 512-bit cache lines: two line buffers feed a vertical
// sum, a horizontal sum follows one line later, border pixels pass the raw centre through.
module gaussian_stencil
  import gaussian_pkg::*;
#(
  parameter int unsigned MAX_ROW_CL = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       cfg_row_cl,
  input  logic [15:0]       cfg_num_rows,
  input  logic [LINE_W-1:0] data_in,
  input  logic              valid_in,
  output logic [LINE_W-1:0] data_out,
  output logic              valid_out,
  output logic              done,
  output logic              err
);

  localparam int unsigned AddrW = $clog2(MAX_ROW_CL);

  t_stencil_state   state_q, state_d;
  logic [15:0]      w_q, w_d, r_q, r_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d, drain_q, drain_d;
  logic [CNT_W-1:0] w_cnt, w_last, r_last;
  logic             err_q, err_d, done_q, done_d;
  logic             cfg_bad, step, last_in;
  t_pix_line        line_in;

  // Stage 1: RAM outputs and the bottom line for the line just accepted.
  logic             s1_valid_q;
  logic [CNT_W-1:0] s1_col_q, s1_row_q;
  t_pix_line        top_q, mid_q, bot_q;

  // Stage 2: centre line n, whose right neighbour's V arrives with the next stage-1 line.
  logic             h_valid_q;
  logic [CNT_W-1:0] h_col_q, h_row_q;
  t_pix_line        raw_q;
  t_vsum_line       v_cur_q, v_next;
  t_vsum            v_prev_last_q;
  t_pix_line        h_line, out_line;
  logic             emit, last_out;

  logic [LINE_W-1:0] data_out_q;
  logic              valid_out_q;

  assign w_cnt   = CNT_W'(w_q);
  assign w_last  = w_cnt - CNT_W'(1);
  assign r_last  = CNT_W'(r_q) - CNT_W'(1);
  assign cfg_bad = (cfg_row_cl < 16'd2) || ({16'd0, cfg_row_cl} > MAX_ROW_CL) ||
                   (cfg_num_rows < 16'd3);

  // Drain injects zero lines so the last row can be flushed through both stages.
  assign step    = ((state_q == StRun) && valid_in) || (state_q == StDrain);
  assign line_in = (state_q == StRun) ? t_pix_line'(data_in) : '0;
  assign last_in = (col_q == w_last) && (row_q == r_last);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    r_d     = r_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    err_d   = err_q;
    done_d  = done_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          w_d     = cfg_row_cl;
          r_d     = cfg_num_rows;
          col_d   = '0;
          row_d   = '0;
          drain_d = '0;
          if (cfg_bad) begin
            state_d = StDone;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (valid_in && last_in) state_d = StDrain;
      end
      StDrain: begin
        drain_d = drain_q + CNT_W'(1);
        if (drain_q == w_cnt) state_d = StDone;
        if (valid_in) err_d = 1'b1;
      end
      StDone: begin
        if (valid_in) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (step) begin
      if (col_q == w_last) begin
        col_d = '0;
        row_d = row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end

    if (last_out) done_d = 1'b1;
  end

  // B1 holds the previous row (mid); B2 the one before (top). B2 is refilled one cycle later
  // from B1's registered read, which is safe because consecutive lines never share a column.
  gaussian_line_buffer #(
    .Depth (MAX_ROW_CL),
    .Width (LINE_W)
  ) u_buf_mid (
    .clk_i     (clk),
    .rd_en_i   (step),
    .rd_addr_i (col_q[AddrW-1:0]),
    .rd_data_o (mid_q),
    .wr_en_i   (step),
    .wr_addr_i (col_q[AddrW-1:0]),
    .wr_data_i (line_in)
  );

  gaussian_line_buffer #(
    .Depth (MAX_ROW_CL),
    .Width (LINE_W)
  ) u_buf_top (
    .clk_i     (clk),
    .rd_en_i   (step),
    .rd_addr_i (col_q[AddrW-1:0]),
    .rd_data_o (top_q),
    .wr_en_i   (s1_valid_q),
    .wr_addr_i (s1_col_q[AddrW-1:0]),
    .wr_data_i (mid_q)
  );

  assign v_next = vsum_line(top_q, mid_q, bot_q);
  assign h_line = hsum_line(v_prev_last_q, v_cur_q, v_next[0]);

  always_comb begin
    out_line = h_line;
    if ((h_row_q == '0) || (h_row_q == r_last)) out_line = raw_q;
    if (h_col_q == '0) out_line[0] = raw_q[0];
    if (h_col_q == w_last) out_line[PIX_PER_LINE-1] = raw_q[PIX_PER_LINE-1];
  end

  assign emit     = s1_valid_q && h_valid_q;
  assign last_out = emit && (h_row_q == r_last) && (h_col_q == w_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      w_q         <= '0;
      r_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      h_valid_q   <= 1'b0;
      h_col_q     <= '0;
      h_row_q     <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      r_q         <= r_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      err_q       <= err_d;
      done_q      <= done_d;
      s1_valid_q  <= step;
      valid_out_q <= emit;
      if (step) begin
        s1_col_q <= col_q;
        s1_row_q <= row_q;
      end
      // The centre of a stage-1 line sits in the same column one row up.
      if (s1_valid_q) begin
        h_valid_q <= (s1_row_q != '0);
        h_col_q   <= s1_col_q;
        h_row_q   <= s1_row_q - CNT_W'(1);
      end
      if (emit) data_out_q <= out_line;
    end
  end

  always_ff @(posedge clk) begin
    if (step) bot_q <= line_in;
    if (s1_valid_q) begin
      v_prev_last_q <= v_cur_q[PIX_PER_LINE-1];
      v_cur_q       <= v_next;
      raw_q         <= mid_q;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_gaussian_stencil.sv
// Directed bench for gaussian_stencil with hand-computed pixels and a 2D reference filter.
module tb_gaussian_stencil;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  cfg_row_cl = '0;
  logic [15:0]  cfg_num_rows = '0;
  logic [511:0] data_in = '0;
  logic         valid_in = 1'b0;
  logic [511:0] data_out;
  logic         valid_out;
  logic         done;
  logic         err;

  gaussian_stencil #(
    .MAX_ROW_CL (64),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .cfg_row_cl   (cfg_row_cl),
    .cfg_num_rows (cfg_num_rows),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [511:0] img   [0:127];
  logic [511:0] cap   [0:511];
  int           cap_t [0:511];
  int           acc_t [0:127];
  int           cap_n = 0;

  always @(negedge clk) begin
    if (valid_out && cap_n < 512) begin
      cap[cap_n]   = data_out;
      cap_t[cap_n] = cyc;
      cap_n++;
    end
  end

  function automatic logic [7:0] px(int w, int r, int x);
    logic [511:0] ln;
    ln = img[r * w + x / 64];
    return ln[(x % 64) * 8 +: 8];
  endfunction

  // Direct 2D convolution on the image, borders copied.
  function automatic logic [511:0] model_line(int w, int rr, int n);
    logic [511:0] res;
    int r, c, x, s, k;
    r = n / w;
    c = n % w;
    res = '0;
    for (int p = 0; p < 64; p++) begin
      x = c * 64 + p;
      if (r == 0 || r == rr - 1 || x == 0 || x == w * 64 - 1) begin
        res[p*8 +: 8] = px(w, r, x);
      end else begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            k = ((dr == 0) ? 2 : 1) * ((dx == 0) ? 2 : 1);
            s += k * int'(px(w, r + dr, x + dx));
          end
        end
        res[p*8 +: 8] = 8'((s + 8) >> 4);
      end
    end
    return res;
  endfunction

  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_frame(input int w, input int r);
    cfg_row_cl   = 16'(w);
    cfg_num_rows = 16'(r);
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int w, input int r, input int gap, output int base);
    int k;
    base = cap_n;
    start_frame(w, r);
    for (int j = 0; j < w * r; j++) begin
      valid_in = 1'b1;
      data_in  = img[j];
      acc_t[j] = cyc;
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = '0;
      repeat (gap) @(negedge clk);
    end
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_done: done=%b after %0d cycles, want 1", done, k);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    n_vec++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_flat();
    int base;
    logic [511:0] flat;
    flat = {64{8'h80}};
    do_reset();
    for (int j = 0; j < 6; j++) img[j] = flat;
    run_frame(2, 3, 0, base);
    n_vec++; if (cap_n - base !== 6) begin n_bad++; $display("FAIL flat_count: got %0d want 6", cap_n - base); end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (cap[base+i] !== flat) begin n_bad++; $display("FAIL flat_line%0d: got %h want %h", i, cap[base+i], flat); end
    end
    n_vec++;
    if (cap_t[base] !== acc_t[3] + 2) begin
      n_bad++; $display("FAIL flat_latency: first pulse cycle %0d want %0d", cap_t[base], acc_t[3] + 2);
    end
    n_vec++;
    if (cap_t[base+5] !== cap_t[base] + 5) begin
      n_bad++; $display("FAIL flat_b2b: last pulse cycle %0d want %0d", cap_t[base+5], cap_t[base] + 5);
    end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL flat_err: got %b want 0", err); end
    // A line after the frame is complete is dropped and flagged.
    valid_in = 1'b1;
    data_in  = flat;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL extra_err: got %b want 1", err); end
    n_vec++; if (cap_n - base !== 6) begin n_bad++; $display("FAIL extra_count: got %0d want 6", cap_n - base); end
  endtask

  task automatic test_impulse();
    int base;
    logic [511:0] t, o;
    do_reset();
    for (int j = 0; j < 6; j++) img[j] = '0;
    t = '0;
    t[32*8 +: 8] = 8'hFF;
    img[2] = t;
    run_frame(2, 3, 0, base);
    n_vec++; if (cap_n - base !== 6) begin n_bad++; $display("FAIL imp_count: got %0d want 6", cap_n - base); end
    o = cap[base+2];
    n_vec++; if (o[31*8 +: 8] !== 8'h20) begin n_bad++; $display("FAIL imp_p31: got %h want 20", o[31*8 +: 8]); end
    n_vec++; if (o[32*8 +: 8] !== 8'h40) begin n_bad++; $display("FAIL imp_p32: got %h want 40", o[32*8 +: 8]); end
    n_vec++; if (o[33*8 +: 8] !== 8'h20) begin n_bad++; $display("FAIL imp_p33: got %h want 20", o[33*8 +: 8]); end
    n_vec++; if (o[30*8 +: 8] !== 8'h00) begin n_bad++; $display("FAIL imp_p30: got %h want 00", o[30*8 +: 8]); end
    n_vec++; if (cap[base+0] !== '0) begin n_bad++; $display("FAIL imp_row0: got %h want 0", cap[base+0]); end
    n_vec++; if (cap[base+4] !== '0) begin n_bad++; $display("FAIL imp_row2: got %h want 0", cap[base+4]); end
  endtask

  task automatic test_cross();
    int base;
    logic [511:0] t, o;
    do_reset();
    for (int j = 0; j < 8; j++) img[j] = '0;
    t = '0;
    t[63*8 +: 8] = 8'hF0;
    img[2] = t;
    run_frame(2, 4, 0, base);
    n_vec++; if (cap_n - base !== 8) begin n_bad++; $display("FAIL cross_count: got %0d want 8", cap_n - base); end
    o = cap[base+2];
    n_vec++; if (o[63*8 +: 8] !== 8'h3C) begin n_bad++; $display("FAIL cross_r1c0_p63: got %h want 3c", o[63*8 +: 8]); end
    n_vec++; if (o[62*8 +: 8] !== 8'h1E) begin n_bad++; $display("FAIL cross_r1c0_p62: got %h want 1e", o[62*8 +: 8]); end
    o = cap[base+3];
    n_vec++; if (o[0 +: 8] !== 8'h1E) begin n_bad++; $display("FAIL cross_r1c1_p0: got %h want 1e", o[0 +: 8]); end
    o = cap[base+4];
    n_vec++; if (o[63*8 +: 8] !== 8'h1E) begin n_bad++; $display("FAIL cross_r2c0_p63: got %h want 1e", o[63*8 +: 8]); end
    o = cap[base+5];
    n_vec++; if (o[0 +: 8] !== 8'h0F) begin n_bad++; $display("FAIL cross_r2c1_p0: got %h want 0f", o[0 +: 8]); end
  endtask

  task automatic test_ramp();
    int base;
    logic [511:0] ramp, o;
    do_reset();
    for (int p = 0; p < 64; p++) ramp[p*8 +: 8] = 8'(p);
    for (int j = 0; j < 9; j++) img[j] = ramp;
    run_frame(3, 3, 0, base);
    n_vec++; if (cap_n - base !== 9) begin n_bad++; $display("FAIL ramp_count: got %0d want 9", cap_n - base); end
    for (int i = 0; i < 9; i++) begin
      if (i < 3 || i > 5) begin
        n_vec++;
        if (cap[base+i] !== ramp) begin n_bad++; $display("FAIL ramp_border_line%0d: got %h want %h", i, cap[base+i], ramp); end
      end
    end
    o = cap[base+3];
    n_vec++; if (o[0 +: 8] !== 8'd0) begin n_bad++; $display("FAIL ramp_c0_p0: got %0d want 0", o[0 +: 8]); end
    n_vec++; if (o[63*8 +: 8] !== 8'd47) begin n_bad++; $display("FAIL ramp_c0_p63: got %0d want 47", o[63*8 +: 8]); end
    o = cap[base+4];
    n_vec++; if (o[0 +: 8] !== 8'd16) begin n_bad++; $display("FAIL ramp_c1_p0: got %0d want 16", o[0 +: 8]); end
    n_vec++; if (o[10*8 +: 8] !== 8'd10) begin n_bad++; $display("FAIL ramp_c1_p10: got %0d want 10", o[10*8 +: 8]); end
    o = cap[base+5];
    n_vec++; if (o[63*8 +: 8] !== 8'd63) begin n_bad++; $display("FAIL ramp_c2_p63: got %0d want 63", o[63*8 +: 8]); end
  endtask

  task automatic test_gapped();
    int base;
    logic [511:0] t;
    logic [511:0] expv [0:19];
    for (int j = 0; j < 20; j++) begin
      for (int q = 0; q < 16; q++) t[q*32 +: 32] = $urandom();
      img[j] = t;
    end
    for (int n = 0; n < 20; n++) expv[n] = model_line(4, 5, n);
    for (int g = 0; g < 3; g += 2) begin
      do_reset();
      run_frame(4, 5, g, base);
      n_vec++; if (cap_n - base !== 20) begin n_bad++; $display("FAIL gap%0d_count: got %0d want 20", g, cap_n - base); end
      for (int n = 0; n < 20; n++) begin
        n_vec++;
        if (cap[base+n] !== expv[n]) begin n_bad++; $display("FAIL gap%0d_line%0d: got %h want %h", g, n, cap[base+n], expv[n]); end
      end
      for (int n = 0; n + 5 < 20; n++) begin
        n_vec++;
        if (cap_t[base+n] !== acc_t[n+5] + 2) begin
          n_bad++; $display("FAIL gap%0d_lat%0d: got cycle %0d want %0d", g, n, cap_t[base+n], acc_t[n+5] + 2);
        end
      end
    end
  endtask

  task automatic test_errors();
    int base;
    // (row_cl, num_rows) pairs that must be rejected
    int bad_w [0:2] = '{1, 65, 4};
    int bad_r [0:2] = '{3, 3, 2};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      base = cap_n;
      start_frame(bad_w[i], bad_r[i]);
      for (int j = 0; j < 4; j++) begin
        valid_in = 1'b1;
        data_in  = {64{8'h55}};
        @(negedge clk);
      end
      valid_in = 1'b0;
      repeat (8) @(negedge clk);
      n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL cfg%0d_err: got %b want 1", i, err); end
      n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL cfg%0d_done: got %b want 1", i, done); end
      n_vec++; if (cap_n - base !== 0) begin n_bad++; $display("FAIL cfg%0d_count: got %0d want 0", i, cap_n - base); end
    end
    // Widest legal row, abandoned mid-frame by reset.
    do_reset();
    start_frame(64, 3);
    for (int j = 0; j < 70; j++) begin
      valid_in = 1'b1;
      data_in  = {64{8'h33}};
      @(negedge clk);
    end
    valid_in = 1'b0;
    @(negedge clk);
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL wmax_err: got %b want 0", err); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (data_out !== '0) begin n_bad++; $display("FAIL midrst_data: got %h want 0", data_out); end
    n_vec++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", valid_out); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    base = cap_n;
    repeat (10) @(negedge clk);
    n_vec++; if (cap_n - base !== 0) begin n_bad++; $display("FAIL midrst_stale: got %0d pulses want 0", cap_n - base); end
    for (int j = 0; j < 6; j++) img[j] = {64{8'h80}};
    run_frame(2, 3, 0, base);
    n_vec++; if (cap_n - base !== 6) begin n_bad++; $display("FAIL midrst_count: got %0d want 6", cap_n - base); end
    n_vec++;
    if (cap[base+1] !== {64{8'h80}}) begin n_bad++; $display("FAIL midrst_line1: got %h want all 80", cap[base+1]); end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_impulse();
    test_cross();
    test_ramp();
    test_gapped();
    test_errors();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
